// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types, constants and baud divider helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE, PARITY} rx_state_e;
    localparam int DATA_BITS = 8;
    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD003F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD003FC;
    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + baud * oversample / 2) / (baud * oversample);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-clock tick every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 358
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == W'(DIV - 1);
    always_comb cnt_d = tick ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 3-sample majority vote; define UART_RX_PARITY_EN for even parity
module uart_rx_core import uart_pkg::*; #(
    parameter int CLK_FREQ   = 55000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_clear,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);
    localparam int SW = $clog2(OVERSAMPLE);
    logic tick;
    uart_baud_tick #(.DIV(baud_div(CLK_FREQ, BAUD, OVERSAMPLE))) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );
    rx_state_e state_q, state_d;
    logic [1:0] sync_q, sync_d, vote_q, vote_d;
    logic prev_q, prev_d, ready_q, ready_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
`ifdef UART_RX_PARITY_EN
    logic pbad_q, pbad_d, perr_q, perr_d;
    assign parity_err = perr_q;
`endif
    logic rx_s, fall, mid_lo, mid, vote_t, bit_end, maj;
    assign rx_s    = sync_q[1];
    assign fall    = prev_q & ~rx_s;
    assign mid_lo  = tick && cnt_q == SW'(OVERSAMPLE / 2 - 1);
    assign mid     = tick && cnt_q == SW'(OVERSAMPLE / 2);
    assign vote_t  = tick && cnt_q == SW'(OVERSAMPLE / 2 + 1);
    assign bit_end = tick && cnt_q == SW'(OVERSAMPLE - 1);
    assign maj     = (vote_q[0] & vote_q[1]) | (rx_s & (vote_q[0] | vote_q[1]));
    assign rx_data   = data_q;
    assign rx_ready  = ready_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    always_comb begin
        sync_d  = {sync_q[0], rxd};
        prev_d  = rx_s;
        state_d = state_q;
        cnt_d   = tick ? cnt_q + SW'(1) : cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        vote_d  = {mid ? rx_s : vote_q[1], mid_lo ? rx_s : vote_q[0]};
        data_d  = data_q;
        ready_d = rx_clear ? 1'b0 : ready_q;
        ferr_d  = rx_clear ? 1'b0 : ferr_q;
        ovr_d   = rx_clear ? 1'b0 : ovr_q;
`ifdef UART_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = rx_clear ? 1'b0 : perr_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (vote_t && maj) state_d = IDLE;
                else if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (vote_t) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (vote_t) pbad_d = ^shift_q ^ maj;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (vote_t && maj) begin
                    data_d  = shift_q;
                    ready_d = 1'b1;
                    if (ready_q && !rx_clear) ovr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (pbad_q) perr_d = 1'b1;
`endif
                    state_d = IDLE;
                end else if (vote_t) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!rx_s) cnt_d = '0;
                else if (tick) begin
                    cnt_d = SW'(1);
                    if (cnt_q != '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            vote_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            vote_q  <= vote_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against uart_rx_core with a fast divider (DIV=4, 64 clocks per bit)
module tb_uart_rx_core;
    localparam int CLK_FREQ = 614400;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int BIT      = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME  = FRAME_BITS * BIT;
    localparam int LAT_LO = (FRAME_BITS - 1) * BIT + 24;
    localparam int LAT_HI = FRAME;
    logic clk = 1'b0;
    logic rst, rxd, rx_clear;
    logic [7:0] rx_data;
    logic rx_ready, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    logic par_flip = 1'b0;
`endif
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat, comp;
    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rx_clear (rx_clear),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun  (overrun)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic align();
        do @(negedge clk); while (cyc % DIV != 0);
    endtask
    task automatic idle(input int bits);
        rxd = 1'b1;
        repeat (bits * BIT) @(negedge clk);
    endtask
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = ^d ^ par_flip;
        repeat (BIT) @(negedge clk);
`endif
        rxd = stop;
        repeat (BIT) @(negedge clk);
    endtask
    task automatic pulse_clear();
        rx_clear = 1'b1;
        @(negedge clk);
        rx_clear = 1'b0;
    endtask
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rx_clear = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(rx_ready), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        align();
        lat = 0;
        fork
            send_frame(8'h55, 1'b1);
            while (!rx_ready && lat < 2 * FRAME) begin
                @(negedge clk);
                lat++;
            end
        join
        check("lat_55_in_window", 32'(lat >= LAT_LO && lat <= LAT_HI), 1);
        check("ready_55", 32'(rx_ready), 1);
        check("data_55", 32'(rx_data), 'h55);
        check("ferr_55", 32'(frame_err), 0);
        check("ovr_55", 32'(overrun), 0);
        pulse_clear();
        check("clr_ready", 32'(rx_ready), 0);
        idle(1);
        rxd = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        idle(2);
        check("glitch_ready", 32'(rx_ready), 0);
        check("glitch_ferr", 32'(frame_err), 0);
        check("glitch_ovr", 32'(overrun), 0);
        send_frame(8'hA3, 1'b0);
        idle(2);
        check("ferr_a3", 32'(frame_err), 1);
        check("ferr_ready", 32'(rx_ready), 0);
        check("ferr_data_kept", 32'(rx_data), 'h55);
        send_frame(8'h11, 1'b1);
        idle(1);
        check("ready_11", 32'(rx_ready), 1);
        check("data_11", 32'(rx_data), 'h11);
        check("ferr_sticky", 32'(frame_err), 1);
        pulse_clear();
        check("clr_ferr", 32'(frame_err), 0);
        idle(1);
        align();
        send_frame(8'h12, 1'b1);
        comp = 0;
        fork
            send_frame(8'h34, 1'b1);
            for (int n = 1; n <= FRAME; n++) begin
                @(negedge clk);
                if (comp == 0 && rx_data == 8'h34) comp = n;
            end
        join
        check("b2b_ready", 32'(rx_ready), 1);
        check("b2b_data", 32'(rx_data), 'h34);
        check("b2b_ovr", 32'(overrun), 1);
        pulse_clear();
        check("b2b_clr_ovr", 32'(overrun), 0);
        idle(1);
        align();
        send_frame(8'h12, 1'b1);
        fork
            send_frame(8'h34, 1'b1);
            for (int n = 1; n <= FRAME; n++) begin
                @(negedge clk);
                rx_clear = (n == comp - 1);
            end
        join
        rx_clear = 1'b0;
        check("race_ready", 32'(rx_ready), 1);
        check("race_data", 32'(rx_data), 'h34);
        check("race_ovr", 32'(overrun), 0);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("midrst_ready", 32'(rx_ready), 0);
                check("midrst_data", 32'(rx_data), 0);
                check("midrst_ferr", 32'(frame_err), 0);
                check("midrst_ovr", 32'(overrun), 0);
                rst = 1'b0;
            end
        join
        idle(1);
        check("midrst_no_byte", 32'(rx_ready), 0);
        align();
        send_frame(8'h7E, 1'b1);
        idle(1);
        check("ready_7e", 32'(rx_ready), 1);
        check("data_7e", 32'(rx_data), 'h7E);
        check("ferr_7e", 32'(frame_err), 0);
`ifdef UART_RX_PARITY_EN
        check("perr_clean", 32'(parity_err), 0);
        pulse_clear();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(1);
        check("par_bad_data", 32'(rx_data), 'h07);
        check("par_bad_ready", 32'(rx_ready), 1);
        check("par_bad_perr", 32'(parity_err), 1);
        pulse_clear();
        check("par_clr", 32'(parity_err), 0);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(1);
        check("par_ok_ready", 32'(rx_ready), 1);
        check("par_ok_perr", 32'(parity_err), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive front end for the CPU's memory-mapped UART. It samples the raw `rxd` pin and frames 8N1 bytes at the configured baud rate. It holds each byte with a ready flag until the UART controller clears it. Sits directly upstream of the UART controller, which polls `rx_ready`/`rx_data` at 0xBFD003FC/0xBFD003F8 and pulses `rx_clear` on a data read.

Parameters:
- CLK_FREQ, 55000000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s
- OVERSAMPLE, 16, sample ticks per bit; must be a power of two, at least 8

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rxd  input  1  raw asynchronous serial line, idle high
- rx_clear  input  1  single-cycle pulse from controller: consume the held byte
- rx_data  output  8  last received byte, LSB first on line
- rx_ready  output  1  byte held and not yet consumed
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: new byte completed while rx_ready=1

Behaviour:
- Reset values: rx_data=8'h00, rx_ready=0, frame_err=0, overrun=0. FSM returns to IDLE, divider=0, synchronizer flops=1.
- Input path: 2-flop synchronizer on rxd, giving 2-cycle latency into the FSM; all decisions use the synced value.
- Tick generator:
  - DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)), which is 358 at defaults.
  - Counter width is $clog2(DIV).
  - Produces a 1-clk tick pulse every DIV clocks; it is free-running.
- Sample counter: counts ticks 0..OVERSAMPLE-1 within a bit. Mid-bit is tick OVERSAMPLE/2.
- Mid-bit decision is a 3-sample majority vote over ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - On a synced high-to-low transition: sample counter=0, go to START.
- START:
  - At mid-bit, majority=1 means false start: go to IDLE with no flag change.
  - Majority=0: continue to the end of the bit, then go to DATA with bit index=0.
- DATA:
  - At each mid-bit, shift the majority value into the shift register MSB, which is LSB-first assembly.
  - At the end of bit 7, go to STOP.
- STOP, at mid-bit:
  - Majority=1: rx_data<=shift register, rx_ready<=1 next clk. If rx_ready was already 1 and rx_clear is not asserted this cycle, overrun<=1; the new byte overwrites. Go to IDLE immediately without waiting for the end of the stop bit, so back-to-back frames are tolerated.
  - Majority=0: frame_err<=1, byte discarded, rx_ready unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until synced rxd=1 for one full tick, then go to IDLE. This handles the break condition.
- rx_clear:
  - Next clk: rx_ready<=0, frame_err<=0, overrun<=0.
  - If rx_clear coincides with a byte completion, the completion wins: rx_ready stays 1, data is updated, overrun is not set.
  - rx_clear while rx_ready=0 clears the sticky flags only.
- Latency: rx_ready asserts 1 clk after the mid-stop tick, about 9.5 bit times after the start edge plus 2-3 clks.
- Reset mid-frame: all state returns to reset values in the same cycle; the partial byte is dropped.
- rx_data is stable whenever rx_ready=1 until the next completion.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - An even-parity bit is expected between bit 7 and stop, via an added PARITY state.
  - Output `parity_err` (1 bit, sticky) is added; it sets on mismatch at byte completion and clears on rx_clear and reset.
  - On a parity mismatch the byte is still delivered.
- Undefined: 8N1 only, no PARITY state, no parity_err port.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, START, DATA, STOP, WAIT_IDLE, PARITY), DATA_BITS=8, the function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE, and the UART register address constants 0xBFD003F8/0xBFD003FC shared with the controller.
- One sub-module: uart_baud_tick (parameterised divider producing the tick pulse). A matching transmitter can reuse it.

Test Plan:
- Send 0x55 at 9600 8N1 → rx_ready=1 about 9.5 bit times after the start edge, rx_data=0x55, frame_err=0, overrun=0; then pulse rx_clear → rx_ready=0 next clk.
- 3-tick low glitch on idle rxd → FSM back to IDLE, rx_ready stays 0, no flags.
- Send 0xA3 with stop bit driven 0 → frame_err=1, rx_ready=0, rx_data unchanged. Next valid byte 0x11 is accepted after the line returns high.
- Send 0x12 then 0x34 back-to-back with no rx_clear → rx_ready=1, rx_data=0x34, overrun=1. rx_clear timed on the 0x34 completion cycle → rx_ready=1, overrun=0.
- Assert rst at DATA bit 4 of 0xFF → outputs zero next clk. A subsequent 0x7E is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 → rx_data=0x07, rx_ready=1, parity_err=1. With parity bit 1 → parity_err=0.
